fifo_ctrl_param: RTL and testbench

- Parametrised synchronous FIFO buffer that replaces the fixed 8-bit FIFO RAM in the UART/link datapaths.
- Width and depth are configurable, and the FIFO holds its full depth: an N-word FIFO stores N words.
- Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush, and sticky overflow/underflow error flags.
- Storage is an inferred dual-port array inside the block, with registered read data.

---
 rtl/fifo_ctrl_param.sv | 102 ++++++++++
 tb/tb_fifo_ctrl_param.sv | 117 +++++++++++
 2 files changed

// File: rtl/fifo_ctrl_param.sv
// fifo_ctrl_param: parametrised synchronous FIFO with occupancy, thresholds, flush and sticky errors.
module fifo_ctrl_param #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_LEVEL  = 2**ADDR_WIDTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  flush_i,
  input  logic                  clear_errors_i,
  input  logic                  write_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic                  read_i,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  data_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);
  if (ADDR_WIDTH < 1) begin : g_aw_chk
    $error("ADDR_WIDTH must be >= 1");
  end
  if (!(ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL && ALMOST_FULL_LEVEL <= DEPTH)) begin : g_lvl_chk
    $error("require ALMOST_EMPTY_LEVEL < ALMOST_FULL_LEVEL <= DEPTH");
  end
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic data_valid_q, full_q, empty_q, afull_q, aempty_q, ovf_q, udf_q;
  logic data_valid_d, full_d, empty_d, afull_d, aempty_d, ovf_d, udf_d;
  logic flush_c, clr_c, wr_acc, rd_acc;
  always_comb begin
    flush_c      = enable_i & flush_i;
    clr_c        = enable_i & clear_errors_i;
    wr_acc       = enable_i & write_i & ~full_q & ~flush_i;
    rd_acc       = enable_i & read_i & ~empty_q & ~flush_i;
    wptr_d       = flush_c ? '0 : wr_acc ? wptr_q + ADDR_WIDTH'(1) : wptr_q;
    rptr_d       = flush_c ? '0 : rd_acc ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
    count_d      = flush_c             ? '0 :
                   wr_acc && !rd_acc   ? count_q + (ADDR_WIDTH+1)'(1) :
                   rd_acc && !wr_acc   ? count_q - (ADDR_WIDTH+1)'(1) : count_q;
    // flags track the next count so they line up with count_o after the edge
    full_d       = count_d == DEPTH_C;
    empty_d      = count_d == '0;
    afull_d      = count_d >= AF_C;
    aempty_d     = count_d <= AE_C;
    data_out_d   = rd_acc ? mem[rptr_q] : data_out_q;
    data_valid_d = rd_acc;
    ovf_d        = (enable_i & write_i & full_q & ~flush_i) | (ovf_q & ~clr_c);
    udf_d        = (enable_i & read_i & empty_q & ~flush_i) | (udf_q & ~clr_c);
  end
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wptr_q] <= data_in_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      afull_q      <= 1'b0;
      aempty_q     <= 1'b1;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      afull_q      <= afull_d;
      aempty_q     <= aempty_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end
  assign data_out_o     = data_out_q;
  assign data_valid_o   = data_valid_q;
  assign full_o         = full_q;
  assign empty_o        = empty_q;
  assign almost_full_o  = afull_q;
  assign almost_empty_o = aempty_q;
  assign count_o        = count_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;
endmodule

// File: tb/tb_fifo_ctrl_param.sv
// tb_fifo_ctrl_param: directed self-checking bench, DEPTH 8, AF 6, AE 2.
module tb_fifo_ctrl_param;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 1'b1, fl = 1'b0, clr = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0] din = '0, dout;
  logic dv, full, empty, af, ae, ovf, udf;
  logic [3:0] cnt;
  int checks = 0, errors = 0;
  fifo_ctrl_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ALMOST_FULL_LEVEL(6), .ALMOST_EMPTY_LEVEL(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .flush_i(fl), .clear_errors_i(clr),
    .write_i(wr), .data_in_i(din), .read_i(rd), .data_out_o(dout), .data_valid_o(dv),
    .full_o(full), .empty_o(empty), .almost_full_o(af), .almost_empty_o(ae),
    .count_o(cnt), .overflow_o(ovf), .underflow_o(udf));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    wr = 1'b0; rd = 1'b0; fl = 1'b0; clr = 1'b0;
  endtask
  task automatic push(input logic [7:0] d);
    wr = 1'b1; din = d;
    step();
  endtask
  initial begin
    #12;
    chk("rst_cnt", cnt, 0); chk("rst_empty", empty, 1); chk("rst_ae", ae, 1);
    chk("rst_full", full, 0); chk("rst_af", af, 0); chk("rst_dv", dv, 0);
    chk("rst_dout", dout, 0); chk("rst_ovf", ovf, 0); chk("rst_udf", udf, 0);
    rst_n = 1'b1;
    // fill, overflow, drain
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    chk("fill_cnt", cnt, 8); chk("fill_full", full, 1); chk("fill_af", af, 1); chk("fill_empty", empty, 0);
    push(8'hFF);
    chk("ovf_cnt", cnt, 8); chk("ovf_flag", ovf, 1); chk("ovf_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      rd = 1'b1;
      step();
      chk("drain_dout", dout, 8'h10 + 8'(i)); chk("drain_dv", dv, 1);
    end
    chk("drain_empty", empty, 1); chk("drain_cnt", cnt, 0); chk("drain_udf", udf, 0);
    step();
    chk("idle_dv", dv, 0); chk("idle_dout_hold", dout, 8'h17);
    clr = 1'b1; step();
    chk("clr_ovf", ovf, 0);
    // thresholds
    push(8'hA0); push(8'hA1);
    chk("th2_ae", ae, 1); chk("th2_cnt", cnt, 2);
    push(8'hA2);
    chk("th3_ae", ae, 0);
    push(8'hA3); push(8'hA4);
    chk("th5_af", af, 0);
    push(8'hA5);
    chk("th6_af", af, 1); chk("th6_cnt", cnt, 6);
    rd = 1'b1; step();
    chk("th_rd_af", af, 0); chk("th_rd_cnt", cnt, 5); chk("th_rd_dout", dout, 8'hA0);
    // flush beats a same-cycle write
    fl = 1'b1; wr = 1'b1; din = 8'hEE; step();
    chk("fl_cnt", cnt, 0); chk("fl_empty", empty, 1); chk("fl_ae", ae, 1); chk("fl_dv", dv, 0);
    chk("fl_dout_hold", dout, 8'hA0);
    push(8'h33);
    rd = 1'b1; step();
    chk("fl_restart", dout, 8'h33); chk("fl_restart_cnt", cnt, 0);
    // wrap-around with 3 resident words
    push(8'h50); push(8'h51); push(8'h52);
    for (int i = 0; i < 20; i++) begin
      wr = 1'b1; rd = 1'b1; din = 8'h60 + 8'(i);
      step();
      chk("wrap_dout", dout, (i < 3) ? 8'h50 + 8'(i) : 8'h60 + 8'(i - 3));
      chk("wrap_cnt", cnt, 3);
    end
    // full: set beats clear, then read+write at full
    for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
    chk("full2_cnt", cnt, 8);
    wr = 1'b1; clr = 1'b1; din = 8'hFE; step();
    chk("setwins_ovf", ovf, 1); chk("setwins_cnt", cnt, 8);
    wr = 1'b1; rd = 1'b1; din = 8'h99; step();
    chk("fullrw_dout", dout, 8'h71); chk("fullrw_cnt", cnt, 7); chk("fullrw_ovf", ovf, 1); chk("fullrw_full", full, 0);
    clr = 1'b1; step();
    chk("clr2_ovf", ovf, 0);
    for (int i = 0; i < 7; i++) begin
      rd = 1'b1; step();
      chk("rej_order", dout, (i < 2) ? 8'h72 + 8'(i) : 8'h80 + 8'(i - 2));
    end
    chk("rej_empty", empty, 1);
    // empty: read+write
    wr = 1'b1; rd = 1'b1; din = 8'h42; step();
    chk("emptyrw_cnt", cnt, 1); chk("emptyrw_udf", udf, 1); chk("emptyrw_dv", dv, 0); chk("emptyrw_dout", dout, 8'h84);
    rd = 1'b1; step();
    chk("emptyrw_rd", dout, 8'h42); chk("emptyrw_cnt0", cnt, 0);
    // enable low freezes state
    en = 1'b0; wr = 1'b1; din = 8'h11; step();
    chk("dis_cnt", cnt, 0); chk("dis_empty", empty, 1);
    en = 1'b0; clr = 1'b1; step();
    chk("dis_udf", udf, 1);
    en = 1'b1;
    // async reset between edges
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    chk("pre_rst_cnt", cnt, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt, 0); chk("arst_empty", empty, 1); chk("arst_ae", ae, 1);
    chk("arst_udf", udf, 0); chk("arst_dout", dout, 0);
    #3 rst_n = 1'b1;
    push(8'hD0);
    rd = 1'b1; step();
    chk("arst_restart", dout, 8'hD0); chk("arst_restart_dv", dv, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
